// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Holds the MDU opcode encodings, default latencies, the {hi,lo} payload type
// and small opcode-classification helpers used by e_mdu and mdu_arith.
package e_mdu_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned OP_W            = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [OP_W-1:0] {
    MDU_OP_NONE  = 4'd0,
    MDU_OP_MULT  = 4'd1,
    MDU_OP_MULTU = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_MFHI  = 4'd5,
    MDU_OP_MFLO  = 4'd6,
    MDU_OP_MTHI  = 4'd7,
    MDU_OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  // Any opcode that the hazard unit must treat as an MDU instruction.
  function automatic logic is_mdu_class(input logic [OP_W-1:0] op);
    return (op >= OP_W'(MDU_OP_MULT)) && (op <= OP_W'(MDU_OP_MTLO));
  endfunction

  // Opcodes that start a multi-cycle operation.
  function automatic logic is_multi_cycle(input logic [OP_W-1:0] op);
    return (op >= OP_W'(MDU_OP_MULT)) && (op <= OP_W'(MDU_OP_DIVU));
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: full 64-bit {hi,lo} result for mult/multu/div/divu.
// Ports:
//   op    - MDU opcode
//   a, b  - rs / rt operands
//   res   - {hi,lo} result (zero for non-arithmetic ops)
//   wr_en - result may be committed (low for non-arithmetic ops and divide by zero)
module mdu_arith
  import e_mdu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output hilo_t             res,
  output logic              wr_en
);

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W-1:0]   div_u;
  logic [DATA_W-1:0]   div_s;
  logic [DATA_W-1:0]   q_u;
  logic [DATA_W-1:0]   r_u;
  logic [DATA_W-1:0]   q_mag;
  logic [DATA_W-1:0]   r_mag;
  logic [DATA_W-1:0]   q_s;
  logic [DATA_W-1:0]   r_s;
  logic                b_zero;

  // Sign-extended operands give the exact signed product modulo 2^64.
  assign prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Signed divide via magnitudes; 0x80000000 maps to itself, which yields
  // the architected overflow result without a special case.
  assign mag_a  = a[DATA_W-1] ? DATA_W'(-a) : a;
  assign mag_b  = b[DATA_W-1] ? DATA_W'(-b) : b;
  assign b_zero = (b == '0);

  // Divisors forced to 1 on divide-by-zero keep the dividers well defined.
  assign div_u = b_zero ? DATA_W'(1) : b;
  assign div_s = b_zero ? DATA_W'(1) : mag_b;

  assign q_u   = a / div_u;
  assign r_u   = a % div_u;
  assign q_mag = mag_a / div_s;
  assign r_mag = mag_a % div_s;

  assign q_s = (a[DATA_W-1] ^ b[DATA_W-1]) ? DATA_W'(-q_mag) : q_mag;
  assign r_s = a[DATA_W-1] ? DATA_W'(-r_mag) : r_mag;

  // Result select.
  always_comb begin
    res   = '0;
    wr_en = 1'b0;
    case (mdu_op_e'(op))
      MDU_OP_MULT: begin
        res   = prod_s;
        wr_en = 1'b1;
      end
      MDU_OP_MULTU: begin
        res   = prod_u;
        wr_en = 1'b1;
      end
      MDU_OP_DIV: begin
        res.hi = r_s;
        res.lo = q_s;
        wr_en  = !b_zero;
      end
      MDU_OP_DIVU: begin
        res.hi = r_u;
        res.lo = q_u;
        wr_en  = !b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - qualified MDU instruction in E this cycle
//   mdu_op            - MDU opcode
//   rs_val, rt_val    - forwarded operands
//   busy              - multi-cycle operation in flight
//   stall_req         - stall request to the hazard unit
//   hi_out, lo_out    - committed HI / LO
//   mdu_rd            - mfhi/mflo read data (combinational, committed values only)
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   mdu_op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              stall_req,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic [DATA_W-1:0] mdu_rd
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  hilo_t             shadow_q, shadow_d;
  logic              shadow_wr_q, shadow_wr_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  hilo_t             arith_res;
  logic              arith_wr;

  mdu_arith u_arith (
    .op    (mdu_op),
    .a     (rs_val),
    .b     (rt_val),
    .res   (arith_res),
    .wr_en (arith_wr)
  );

  // State, counter, shadow and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      shadow_wr_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      shadow_wr_q <= shadow_wr_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  // Next state: launch from IDLE, count down in RUN, commit on the last edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    shadow_wr_d = shadow_wr_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (mdu_op_e'(mdu_op))
            MDU_OP_MULT, MDU_OP_MULTU: begin
              state_d     = ST_RUN;
              cnt_d       = CNT_W'(MULT_CYCLES);
              shadow_d    = arith_res;
              shadow_wr_d = arith_wr;
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
              state_d     = ST_RUN;
              cnt_d       = CNT_W'(DIV_CYCLES);
              shadow_d    = arith_res;
              shadow_wr_d = arith_wr;
            end
            MDU_OP_MTHI: hi_d = rs_val;
            MDU_OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Any start while running is ignored; the hazard unit holds it.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (shadow_wr_q) begin
            hi_d = shadow_q.hi;
            lo_d = shadow_q.lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read port sees committed registers only, never the shadow copy.
  always_comb begin
    mdu_rd = '0;
    case (mdu_op_e'(mdu_op))
      MDU_OP_MFHI: mdu_rd = hi_q;
      MDU_OP_MFLO: mdu_rd = lo_q;
      default: ;
    endcase
  end

  assign busy      = (state_q == ST_RUN);
  assign stall_req = (start & is_mdu_class(mdu_op)) | busy;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Consumes the E-stage operands that the D/E pipeline register delivers, and owns the architectural HI and LO registers.
- Presents mfhi/mflo results to the E/M pipeline register.
- Raises a busy/stall request; the hazard logic uses it to drop en on the F/D and D/E registers while a multi-cycle operation is outstanding.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu.
- DIV_CYCLES, 10: busy cycles for div/divu.
- CNT_W, 4: counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is a valid MDU op this cycle (already qualified by D/E stall/flush).
- mdu_op  input  4  operation code; encodings are in the shared package.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- busy  output  1  multi-cycle operation in flight.
- stall_req  output  1  asserted when (start & op is MDU-class) | busy, where MDU-class means mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- hi_out  output  32  committed HI.
- lo_out  output  32  committed LO.
- mdu_rd  output  32  mfhi → HI; mflo → LO; otherwise 0. Combinational from committed regs.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - HI, LO, shadow HI/LO, counter → 0; busy → 0.
  - Any in-flight operation is aborted with no commit.
- Initial values match reset values.
- States:
  - IDLE: counter==0, busy=0.
  - RUN: counter>0, busy=1.
- IDLE → RUN:
  - Trigger: edge where start=1 and mdu_op ∈ {MULT, MULTU, DIV, DIVU}.
  - On that edge, the full 64-bit result is computed from rs_val/rt_val and latched into shadow HI/LO.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter==1, shadow is copied into HI/LO and the state returns to IDLE.
  - Latency: start sampled at edge T; busy high for exactly N cycles after T; new HI/LO visible from edge T+N.
- Arithmetic:
  - mult: signed 32×32 → 64; HI = [63:32], LO = [31:0].
  - multu: unsigned 32×32 → 64, same split.
  - div: signed; LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - div overflow: 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (div/divu with rt_val==0): counter runs normally; HI/LO are not modified at commit.
- mthi / mtlo:
  - Accepted when start=1 and busy=0; writes rs_val to HI or LO at that edge.
  - No busy cycles.
- mfhi / mflo:
  - Pure combinational read of committed HI/LO via mdu_rd.
  - Never sees shadow values.
- start=1 while busy=1 (any op):
  - Ignored; state and HI/LO unchanged.
  - The hazard unit guarantees this never carries a real instruction; stall_req stays high.
- Start on the same edge as commit: impossible, since busy=1 on that edge; the new op is ignored per the rule above.
- mdu_op = NONE or an unknown code with start=1: no effect; stall_req = busy only.
- reset=1 and start=1 on the same edge: reset wins.

Decomposition:
- Shared package (mips_defs):
  - MDU_OP_* encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - MULT_CYCLES and DIV_CYCLES default constants.
- Sub-module: one natural one, mdu_arith.
  - Purely combinational: op plus operands → 64-bit {hi,lo} and a wr_en flag (0 for divide-by-zero).
  - Keeps signed/unsigned corner cases testable in isolation.
- Counter/FSM and HI/LO registers stay in e_mdu.

Test Plan:
- Reset then idle → hi_out=lo_out=0, busy=0, stall_req=0, mdu_rd=0.
- mult with rs=0xFFFFFFFE (−2), rt=3 at edge T → busy 1 for edges T+1..T+5 (5 cycles); at T+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall_req high throughout.
- multu with rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div sequence:
  - div rs=−7 (0xFFFFFFF9), rt=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - Then divu with rt=0 → busy 10 cycles; HI/LO unchanged.
- Commit-boundary sequence:
  - mthi 0x12345678 then mflo → HI=0x12345678 next cycle; mdu_rd=LO.
  - Start a mult, drive start+MTLO mid-run → ignored; LO equals the mult result at commit.
- Reset mid-run: start div, assert reset at cycle 4 → busy=0 next edge, HI=LO=0, no later commit.
